axi_lite_arb2: RTL

Two-master AXI4-Lite arbiter that shares the single system AXI4-Lite bus between the core's bus/system-control unit (master 0) and the JTAG debug/DMA port (master 1). Grants one whole transaction at a time (address + data + response), round-robin when both request, and forwards channels combinationally once granted. Sits between the masters and the bus interconnect/slave decoder.

---
 rtl/axi_lite_arb2_pkg.sv | 24 ++
 rtl/axi_lite_arb2_if.sv | 41 ++++
 rtl/axi_lite_arb2_rr_arb2.sv | 27 ++
 rtl/axi_lite_arb2.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/axi_lite_arb2_pkg.sv
// Shared widths, FSM state encodings and AXI response codes for the two-master AXI4-Lite arbiter.
package axi_lite_arb2_pkg;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned SW = DW / 8;
    localparam int unsigned PW = 3;
    localparam int unsigned RW = 2;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_WR   = 2'd1,
        ARB_RD   = 2'd2,
        ARB_ERR  = 2'd3
    } arb_state_e;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_EXOKAY = 2'b01,
        RESP_SLVERR = 2'b10,
        RESP_DECERR = 2'b11
    } axi_resp_e;

endpackage

// File: rtl/axi_lite_arb2_if.sv
// AXI4-Lite bus bundle; master modport drives requests, slave modport drives responses.
interface axi_lite_arb2_if;
    import axi_lite_arb2_pkg::*;

    logic [AW-1:0] awaddr;
    logic [PW-1:0] awprot;
    logic          awvalid;
    logic          awready;
    logic [DW-1:0] wdata;
    logic [SW-1:0] wstrb;
    logic          wvalid;
    logic          wready;
    logic [RW-1:0] bresp;
    logic          bvalid;
    logic          bready;
    logic [AW-1:0] araddr;
    logic [PW-1:0] arprot;
    logic          arvalid;
    logic          arready;
    logic [DW-1:0] rdata;
    logic [RW-1:0] rresp;
    logic          rvalid;
    logic          rready;

    modport master (
        output awaddr, awprot, awvalid, input awready,
        output wdata, wstrb, wvalid, input wready,
        input bresp, bvalid, output bready,
        output araddr, arprot, arvalid, input arready,
        input rdata, rresp, rvalid, output rready
    );

    modport slave (
        input awaddr, awprot, awvalid, output awready,
        input wdata, wstrb, wvalid, output wready,
        output bresp, bvalid, input bready,
        input araddr, arprot, arvalid, output arready,
        output rdata, rresp, rvalid, input rready
    );

endinterface

// File: rtl/axi_lite_arb2_rr_arb2.sv
// Two-requester round-robin picker; last pointer resets to 1 so master 0 wins the first tie.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] gnt
);

    logic last_q;

    always_comb begin
        gnt = req;
        if (req == 2'b11) begin
            gnt = last_q ? 2'b01 : 2'b10;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_q <= 1'b1;
        end else if (advance && (req != 2'b00)) begin
            last_q <= gnt[1];
        end
    end

endmodule

// File: rtl/axi_lite_arb2.sv
// Two-master AXI4-Lite arbiter: whole-transaction grants, combinational forwarding once granted.
// Optional watchdog with SLVERR completion enabled by defining ARB_TIMEOUT_EN.
module axi_lite_arb2
    import axi_lite_arb2_pkg::*;
`ifdef ARB_TIMEOUT_EN
#(
    parameter int unsigned TIMEOUT_CYC = 255
)
`endif
(
    input  logic            clk,
    input  logic            rst,
    axi_lite_arb2_if.slave  m0_axi,
    axi_lite_arb2_if.slave  m1_axi,
    axi_lite_arb2_if.master s_axi,
    output logic [1:0]      grant_o
);

    arb_state_e state_q, state_d;
    logic [1:0] grant_q, grant_d, req, gnt;
    logic aw_done_q, aw_done_d, w_done_q, w_done_d, ar_done_q, ar_done_d;
    logic advance, sel;

    logic [AW-1:0] own_awaddr, own_araddr;
    logic [PW-1:0] own_awprot, own_arprot;
    logic [DW-1:0] own_wdata, own_rdata;
    logic [SW-1:0] own_wstrb;
    logic [RW-1:0] own_bresp, own_rresp;
    logic own_awvalid, own_wvalid, own_bready, own_arvalid, own_rready;
    logic own_awready, own_wready, own_bvalid, own_arready, own_rvalid;

`ifdef ARB_TIMEOUT_EN
    localparam int unsigned CNT_W = (TIMEOUT_CYC > 255) ? $clog2(TIMEOUT_CYC + 1) : 8;
    localparam logic DRAIN = 1'b1;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic err_wr_q, err_wr_d;
`else
    localparam logic DRAIN = 1'b0;
`endif

    assign req     = {m1_axi.awvalid | m1_axi.arvalid, m0_axi.awvalid | m0_axi.arvalid};
    assign sel     = grant_q[1];
    assign grant_o = grant_q;

    // Owner-side request mux
    assign own_awaddr  = sel ? m1_axi.awaddr  : m0_axi.awaddr;
    assign own_awprot  = sel ? m1_axi.awprot  : m0_axi.awprot;
    assign own_awvalid = sel ? m1_axi.awvalid : m0_axi.awvalid;
    assign own_wdata   = sel ? m1_axi.wdata   : m0_axi.wdata;
    assign own_wstrb   = sel ? m1_axi.wstrb   : m0_axi.wstrb;
    assign own_wvalid  = sel ? m1_axi.wvalid  : m0_axi.wvalid;
    assign own_bready  = sel ? m1_axi.bready  : m0_axi.bready;
    assign own_araddr  = sel ? m1_axi.araddr  : m0_axi.araddr;
    assign own_arprot  = sel ? m1_axi.arprot  : m0_axi.arprot;
    assign own_arvalid = sel ? m1_axi.arvalid : m0_axi.arvalid;
    assign own_rready  = sel ? m1_axi.rready  : m0_axi.rready;

    rr_arb2 u_rr_arb2 (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .advance (advance),
        .gnt     (gnt)
    );

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        aw_done_d   = aw_done_q;
        w_done_d    = w_done_q;
        ar_done_d   = ar_done_q;
        advance     = 1'b0;
        s_axi.awaddr  = '0;
        s_axi.awprot  = '0;
        s_axi.awvalid = 1'b0;
        s_axi.wdata   = '0;
        s_axi.wstrb   = '0;
        s_axi.wvalid  = 1'b0;
        s_axi.bready  = 1'b0;
        s_axi.araddr  = '0;
        s_axi.arprot  = '0;
        s_axi.arvalid = 1'b0;
        s_axi.rready  = 1'b0;
        own_awready = 1'b0;
        own_wready  = 1'b0;
        own_bvalid  = 1'b0;
        own_bresp   = RW'(RESP_OKAY);
        own_arready = 1'b0;
        own_rvalid  = 1'b0;
        own_rresp   = RW'(RESP_OKAY);
        own_rdata   = '0;
`ifdef ARB_TIMEOUT_EN
        cnt_d    = cnt_q;
        err_wr_d = err_wr_q;
`endif

        case (state_q)
            ARB_IDLE: begin
                // Late responses to an abandoned transaction are swallowed here when draining
                s_axi.bready = DRAIN && !rst;
                s_axi.rready = DRAIN && !rst;
                advance      = 1'b1;
                if (gnt != 2'b00) begin
                    grant_d   = gnt;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    ar_done_d = 1'b0;
                    state_d   = (gnt[1] ? m1_axi.awvalid : m0_axi.awvalid) ? ARB_WR : ARB_RD;
`ifdef ARB_TIMEOUT_EN
                    cnt_d = '0;
`endif
                end
            end
            ARB_WR: begin
                s_axi.awaddr  = own_awaddr;
                s_axi.awprot  = own_awprot;
                s_axi.awvalid = own_awvalid && !aw_done_q;
                s_axi.wdata   = own_wdata;
                s_axi.wstrb   = own_wstrb;
                s_axi.wvalid  = own_wvalid && !w_done_q;
                s_axi.bready  = own_bready;
                own_awready   = s_axi.awready && !aw_done_q;
                own_wready    = s_axi.wready && !w_done_q;
                own_bvalid    = s_axi.bvalid;
                own_bresp     = s_axi.bresp;
                aw_done_d     = aw_done_q || (own_awvalid && s_axi.awready);
                w_done_d      = w_done_q || (own_wvalid && s_axi.wready);
                if (s_axi.bvalid && own_bready) begin
                    state_d = ARB_IDLE;
                    grant_d = '0;
                end
            end
            ARB_RD: begin
                s_axi.araddr  = own_araddr;
                s_axi.arprot  = own_arprot;
                s_axi.arvalid = own_arvalid && !ar_done_q;
                s_axi.rready  = own_rready;
                own_arready   = s_axi.arready && !ar_done_q;
                own_rvalid    = s_axi.rvalid;
                own_rresp     = s_axi.rresp;
                own_rdata     = s_axi.rdata;
                ar_done_d     = ar_done_q || (own_arvalid && s_axi.arready);
                if (s_axi.rvalid && own_rready) begin
                    state_d = ARB_IDLE;
                    grant_d = '0;
                end
            end
`ifdef ARB_TIMEOUT_EN
            ARB_ERR: begin
                s_axi.bready = 1'b1;
                s_axi.rready = 1'b1;
                own_bvalid   = err_wr_q;
                own_bresp    = RW'(RESP_SLVERR);
                own_rvalid   = !err_wr_q;
                own_rresp    = RW'(RESP_SLVERR);
                if ((err_wr_q && own_bready) || (!err_wr_q && own_rready)) begin
                    state_d = ARB_IDLE;
                    grant_d = '0;
                end
            end
`endif
            default: begin
                state_d = ARB_IDLE;
                grant_d = '0;
            end
        endcase

`ifdef ARB_TIMEOUT_EN
        // Watchdog: a transaction still open after TIMEOUT_CYC cycles is completed with SLVERR
        if (((state_q == ARB_WR) || (state_q == ARB_RD)) && (state_d == state_q)) begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
                state_d  = ARB_ERR;
                err_wr_d = (state_q == ARB_WR);
            end
        end
`endif

        m0_axi.awready = own_awready && grant_q[0];
        m0_axi.wready  = own_wready && grant_q[0];
        m0_axi.bvalid  = own_bvalid && grant_q[0];
        m0_axi.bresp   = grant_q[0] ? own_bresp : '0;
        m0_axi.arready = own_arready && grant_q[0];
        m0_axi.rvalid  = own_rvalid && grant_q[0];
        m0_axi.rresp   = grant_q[0] ? own_rresp : '0;
        m0_axi.rdata   = grant_q[0] ? own_rdata : '0;
        m1_axi.awready = own_awready && grant_q[1];
        m1_axi.wready  = own_wready && grant_q[1];
        m1_axi.bvalid  = own_bvalid && grant_q[1];
        m1_axi.bresp   = grant_q[1] ? own_bresp : '0;
        m1_axi.arready = own_arready && grant_q[1];
        m1_axi.rvalid  = own_rvalid && grant_q[1];
        m1_axi.rresp   = grant_q[1] ? own_rresp : '0;
        m1_axi.rdata   = grant_q[1] ? own_rdata : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ARB_IDLE;
            grant_q   <= '0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            ar_done_q <= 1'b0;
`ifdef ARB_TIMEOUT_EN
            cnt_q    <= '0;
            err_wr_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            ar_done_q <= ar_done_d;
`ifdef ARB_TIMEOUT_EN
            cnt_q    <= cnt_d;
            err_wr_q <= err_wr_d;
`endif
        end
    end

endmodule
